gpu_texfill_arbiter: RTL and testbench
======================================

Name: gpu_texfill_arbiter

Overview:
- Sequences all cache-fill traffic for the GPU pixel pipeline over one shared 32-bit VRAM read port.
- Texture-cache line fills are triggered by the pipeline texture-miss/refill request while the pipeline is paused. CLUT-cache loads are triggered at primitive setup.
- Arbitrates between the two requesters, issues burst reads, steers returned beats into the correct cache write port, and signals completion so the pipeline can release its pause.

Parameters:
- TEX_BEATS, 2, 32-bit beats per texture cache line (64-bit line = 4 texels of 16 bits).
- CLUT4_BEATS, 8, beats for a 4bpp CLUT load (16 entries).
- CLUT8_BEATS, 128, beats for an 8bpp CLUT load (256 entries).

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_texFillReq  in  1  level; texture line refill needed (pipeline stalled while high).
- i_texFillAdr  in  17  texture line address, halfword address [18:2].
- o_texFillDone  out  1  one-cycle pulse: line fully written into the texture cache.
- i_clutLoadReq  in  1  one-cycle pulse: load CLUT.
- i_clutAdr  in  15  CLUT base, halfword address [18:4].
- i_clut8bpp  in  1  1 = 256-entry load, 0 = 16-entry load; sampled with i_clutLoadReq.
- o_clutBusy  out  1  high while a CLUT load is pending or in progress.
- o_clutDone  out  1  one-cycle pulse at end of a CLUT load.
- o_memReq  out  1  read burst request.
- o_memAdr  out  18  32-bit word address.
- o_memBeats  out  8  burst length.
- i_memAck  in  1  request accepted.
- i_memDataValid  in  1  read beat valid.
- i_memData  in  32  read beat.
- o_texWrite  out  1  texture cache write strobe.
- o_texWrAdr  out  17  line being written.
- o_texWrBeat  out  1  beat index within line.
- o_clutWrite  out  1  CLUT cache write strobe.
- o_clutWrIdx  out  7  beat index (2 entries per beat).
- o_wrData  out  32  write data to both caches (i_memData registered).

Behaviour:
- Reset values:
  - All outputs are 0. State is IDLE.
  - CLUT-pending flag, beat counter and latched addresses are cleared.
- CLUT request latching:
  - A pulse on i_clutLoadReq sets the pending flag and captures i_clutAdr and i_clut8bpp in any state.
  - A pulse that arrives during a CLUT load re-arms pending; that load reruns after the current one finishes.
  - o_clutBusy = pending | state in {CLUT_REQ, CLUT_DATA}.
- State IDLE: arbitration. Texture has priority.
  - i_texFillReq=1 -> TEX_REQ. Latch the address; o_memAdr={i_texFillAdr,1'b0}; o_memBeats=TEX_BEATS.
  - Otherwise, if pending=1 -> CLUT_REQ. Clear pending; o_memAdr={clutAdr,3'b000}; o_memBeats=8bpp?CLUT8_BEATS:CLUT4_BEATS.
- State TEX_REQ / CLUT_REQ:
  - o_memReq=1, with address and beats held stable until i_memAck.
  - On ack: drop o_memReq in the next cycle, clear the beat counter, go to TEX_DATA / CLUT_DATA.
- State TEX_DATA / CLUT_DATA, each i_memDataValid:
  - Register the data. Next cycle, pulse o_texWrite or o_clutWrite with index = counter, then increment the counter.
  - Beats may be non-contiguous; gaps are legal.
  - When the last beat is received -> DONE_TEX / DONE_CLUT.
- State DONE_*: lasts one cycle.
  - Happens after the last write strobe. Pulses o_texFillDone or o_clutDone, then -> IDLE.
  - i_texFillReq is ignored in DONE_TEX and in the following IDLE cycle. Two-cycle blanking is required because the cache hit/miss status is one cycle late. This prevents a duplicate fill.
- Latency, texture miss with ack in the same cycle and back-to-back beats:
  - req→ack 1 cycle; last beat → write +1; done +2.
- Addressing:
  - Bursts are linear word addresses.
  - VRAM row wrap (1024 halfwords) is not handled; the upstream clamps the CLUT X coordinate.
- Data beats in IDLE/REQ states are ignored; no write is issued.
- Reset mid-burst: immediate return to IDLE, no done pulse, pending cleared. The memory side is reset by the same i_rst.
- A CLUT load in progress is never preempted. A texture miss during it waits; the pipeline is expected idle during CLUT setup.

Test Plan:
- Texture miss: i_texFillReq=1, adr=17'h00123, ack immediate, beats A,B → o_memAdr=18'h00246, beats=2. Writes (beat0=A, beat1=B) to line 17'h00123. One o_texFillDone pulse. No second request although i_texFillReq stays high 1 cycle after done.
- CLUT 4bpp: pulse with clutAdr=15'h0040, 8bpp=0 → o_memAdr=18'h00200, beats=8. o_clutWrIdx 0..7, one o_clutDone. o_clutBusy high from the pulse cycle until done.
- CLUT 8bpp with valid gaps (every other cycle) → 128 writes, idx 0..127 in order, done after the 128th.
- Simultaneous tex miss and CLUT pulse in IDLE → texture burst first, then the CLUT burst. o_clutBusy stays high throughout.
- Reset asserted after the 3rd of 8 CLUT beats → all outputs 0 next cycle. The remaining beats produce no writes, and no done pulse.
- Ack delayed 5 cycles → o_memReq, o_memAdr and o_memBeats held constant for all 6 cycles.

Source files
------------

// File: rtl/gpu_texfill_arbiter.sv
// gpu_texfill_arbiter: shares one 32-bit VRAM read port between texture-cache
// line fills and CLUT-cache loads. It arbitrates between them (texture wins),
// issues linear bursts, steers the returned beats to the matching cache write
// port, and pulses a done strobe once the last beat has been written.
module gpu_texfill_arbiter #(
    parameter int TEX_BEATS   = 2,
    parameter int CLUT4_BEATS = 8,
    parameter int CLUT8_BEATS = 128
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_texFillReq,
    input  logic [16:0] i_texFillAdr,
    output logic        o_texFillDone,
    input  logic        i_clutLoadReq,
    input  logic [14:0] i_clutAdr,
    input  logic        i_clut8bpp,
    output logic        o_clutBusy,
    output logic        o_clutDone,
    output logic        o_memReq,
    output logic [17:0] o_memAdr,
    output logic [7:0]  o_memBeats,
    input  logic        i_memAck,
    input  logic        i_memDataValid,
    input  logic [31:0] i_memData,
    output logic        o_texWrite,
    output logic [16:0] o_texWrAdr,
    output logic        o_texWrBeat,
    output logic        o_clutWrite,
    output logic [6:0]  o_clutWrIdx,
    output logic [31:0] o_wrData
);

    typedef enum logic [2:0] {
        IDLE,
        TEX_REQ,
        TEX_DATA,
        DONE_TEX,
        CLUT_REQ,
        CLUT_DATA,
        DONE_CLUT
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic        clutPending;
    logic [14:0] clutAdrLat;
    logic        clut8bppLat;
    logic [6:0]  beatCnt;
    logic [6:0]  lastIdx;

    logic        startTex;
    logic        startClut;
    logic        beatTake;
    logic        isLastBeat;

    // A CLUT load is outstanding until its burst has fully returned.
    assign o_clutBusy = clutPending || (state == CLUT_REQ) || (state == CLUT_DATA);
    assign isLastBeat = (beatCnt == lastIdx);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk) begin
        if (i_rst) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state and per-cycle control decodes.
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        startTex  = 1'b0;
        startClut = 1'b0;
        beatTake  = 1'b0;
        unique case (state)
            IDLE: begin
                // The done pulse marks the second blanking cycle: the cache
                // miss flag is one cycle stale and would otherwise refetch.
                if (i_texFillReq && !o_texFillDone) begin
                    stateNext = TEX_REQ;
                    startTex  = 1'b1;
                end else if (clutPending) begin
                    stateNext = CLUT_REQ;
                    startClut = 1'b1;
                end
            end
            TEX_REQ:  if (i_memAck) stateNext = TEX_DATA;
            CLUT_REQ: if (i_memAck) stateNext = CLUT_DATA;
            TEX_DATA: begin
                if (i_memDataValid) begin
                    beatTake = 1'b1;
                    if (isLastBeat) stateNext = DONE_TEX;
                end
            end
            CLUT_DATA: begin
                if (i_memDataValid) begin
                    beatTake = 1'b1;
                    if (isLastBeat) stateNext = DONE_CLUT;
                end
            end
            DONE_TEX:  stateNext = IDLE;
            DONE_CLUT: stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // Request latching, burst issue, beat steering and done strobes.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            clutPending   <= 1'b0;
            clutAdrLat    <= '0;
            clut8bppLat   <= 1'b0;
            beatCnt       <= '0;
            lastIdx       <= '0;
            o_memReq      <= 1'b0;
            o_memAdr      <= '0;
            o_memBeats    <= '0;
            o_texWrite    <= 1'b0;
            o_texWrAdr    <= '0;
            o_texWrBeat   <= 1'b0;
            o_clutWrite   <= 1'b0;
            o_clutWrIdx   <= '0;
            o_wrData      <= '0;
            o_texFillDone <= 1'b0;
            o_clutDone    <= 1'b0;
        end else begin
            // A new pulse always wins over the clear, so a request arriving
            // while a load starts or runs re-arms another full load.
            clutPending <= (clutPending && !startClut) || i_clutLoadReq;
            if (i_clutLoadReq) begin
                clutAdrLat  <= i_clutAdr;
                clut8bppLat <= i_clut8bpp;
            end

            o_texWrite    <= 1'b0;
            o_clutWrite   <= 1'b0;
            o_texFillDone <= (state == DONE_TEX);
            o_clutDone    <= (state == DONE_CLUT);

            if (startTex) begin
                o_texWrAdr <= i_texFillAdr;
                o_memAdr   <= {i_texFillAdr, 1'b0};
                o_memBeats <= 8'(TEX_BEATS);
                lastIdx    <= 7'(TEX_BEATS - 1);
                o_memReq   <= 1'b1;
            end

            if (startClut) begin
                o_memAdr   <= {clutAdrLat, 3'b000};
                o_memBeats <= clut8bppLat ? 8'(CLUT8_BEATS) : 8'(CLUT4_BEATS);
                lastIdx    <= clut8bppLat ? 7'(CLUT8_BEATS - 1) : 7'(CLUT4_BEATS - 1);
                o_memReq   <= 1'b1;
            end

            if (((state == TEX_REQ) || (state == CLUT_REQ)) && i_memAck) begin
                o_memReq <= 1'b0;
                beatCnt  <= '0;
            end

            if (beatTake) begin
                o_wrData <= i_memData;
                beatCnt  <= beatCnt + 7'd1;
                if (state == TEX_DATA) begin
                    o_texWrite  <= 1'b1;
                    o_texWrBeat <= beatCnt[0];
                end else begin
                    o_clutWrite <= 1'b1;
                    o_clutWrIdx <= beatCnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_texfill_arbiter.sv
// Directed bench for gpu_texfill_arbiter: texture fill, CLUT 4bpp and 8bpp
// loads, arbitration, reset mid-burst and a delayed acknowledge.
module tb_gpu_texfill_arbiter;

    logic        clk;
    logic        i_rst;
    logic        i_texFillReq;
    logic [16:0] i_texFillAdr;
    logic        o_texFillDone;
    logic        i_clutLoadReq;
    logic [14:0] i_clutAdr;
    logic        i_clut8bpp;
    logic        o_clutBusy;
    logic        o_clutDone;
    logic        o_memReq;
    logic [17:0] o_memAdr;
    logic [7:0]  o_memBeats;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;
    logic        o_texWrite;
    logic [16:0] o_texWrAdr;
    logic        o_texWrBeat;
    logic        o_clutWrite;
    logic [6:0]  o_clutWrIdx;
    logic [31:0] o_wrData;

    int checks = 0;
    int errors = 0;

    gpu_texfill_arbiter dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_texFillReq  (i_texFillReq),
        .i_texFillAdr  (i_texFillAdr),
        .o_texFillDone (o_texFillDone),
        .i_clutLoadReq (i_clutLoadReq),
        .i_clutAdr     (i_clutAdr),
        .i_clut8bpp    (i_clut8bpp),
        .o_clutBusy    (o_clutBusy),
        .o_clutDone    (o_clutDone),
        .o_memReq      (o_memReq),
        .o_memAdr      (o_memAdr),
        .o_memBeats    (o_memBeats),
        .i_memAck      (i_memAck),
        .i_memDataValid(i_memDataValid),
        .i_memData     (i_memData),
        .o_texWrite    (o_texWrite),
        .o_texWrAdr    (o_texWrAdr),
        .o_texWrBeat   (o_texWrBeat),
        .o_clutWrite   (o_clutWrite),
        .o_clutWrIdx   (o_clutWrIdx),
        .o_wrData      (o_wrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " memReq"},    32'(o_memReq),      32'h0);
        check({tag, " memAdr"},    32'(o_memAdr),      32'h0);
        check({tag, " memBeats"},  32'(o_memBeats),    32'h0);
        check({tag, " texWrite"},  32'(o_texWrite),    32'h0);
        check({tag, " texWrAdr"},  32'(o_texWrAdr),    32'h0);
        check({tag, " clutWrite"}, 32'(o_clutWrite),   32'h0);
        check({tag, " clutWrIdx"}, 32'(o_clutWrIdx),   32'h0);
        check({tag, " wrData"},    o_wrData,           32'h0);
        check({tag, " clutBusy"},  32'(o_clutBusy),    32'h0);
        check({tag, " texDone"},   32'(o_texFillDone), 32'h0);
        check({tag, " clutDone"},  32'(o_clutDone),    32'h0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_texFillReq = 1'b0;
        i_texFillAdr = '0;
        i_clutLoadReq = 1'b0;
        i_clutAdr = '0;
        i_clut8bpp = 1'b0;
        i_memAck = 1'b0;
        i_memDataValid = 1'b0;
        i_memData = '0;
        tick();
        tick();
        checkAllZero("reset");
        i_rst = 1'b0;
        tick();

        // ---- Texture miss, immediate ack, back-to-back beats ----
        i_texFillReq = 1'b1;
        i_texFillAdr = 17'h00123;
        tick();
        check("tex req", 32'(o_memReq), 32'h1);
        check("tex adr", 32'(o_memAdr), 32'h00246);
        check("tex beats", 32'(o_memBeats), 32'h2);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        check("tex req dropped", 32'(o_memReq), 32'h0);
        check("tex no early write", 32'(o_texWrite), 32'h0);
        i_memDataValid = 1'b1;
        i_memData = 32'hAAAA_0001;
        tick();
        check("tex wr0", 32'(o_texWrite), 32'h1);
        check("tex wr0 beat", 32'(o_texWrBeat), 32'h0);
        check("tex wr0 data", o_wrData, 32'hAAAA_0001);
        check("tex wr0 line", 32'(o_texWrAdr), 32'h00123);
        i_memData = 32'hBBBB_0002;
        tick();
        i_memDataValid = 1'b0;
        check("tex wr1", 32'(o_texWrite), 32'h1);
        check("tex wr1 beat", 32'(o_texWrBeat), 32'h1);
        check("tex wr1 data", o_wrData, 32'hBBBB_0002);
        check("tex no done with last write", 32'(o_texFillDone), 32'h0);
        tick();
        check("tex done", 32'(o_texFillDone), 32'h1);
        check("tex write off", 32'(o_texWrite), 32'h0);
        tick();
        // Request was still high during the blanked cycle: no refetch.
        check("tex done single", 32'(o_texFillDone), 32'h0);
        check("tex no dup req", 32'(o_memReq), 32'h0);
        i_texFillReq = 1'b0;
        tick();
        check("tex no dup req 2", 32'(o_memReq), 32'h0);

        // ---- CLUT 4bpp ----
        i_clutLoadReq = 1'b1;
        i_clutAdr = 15'h0040;
        i_clut8bpp = 1'b0;
        tick();
        i_clutLoadReq = 1'b0;
        check("c4 busy pending", 32'(o_clutBusy), 32'h1);
        tick();
        check("c4 req", 32'(o_memReq), 32'h1);
        check("c4 adr", 32'(o_memAdr), 32'h00200);
        check("c4 beats", 32'(o_memBeats), 32'h8);
        check("c4 busy req", 32'(o_clutBusy), 32'h1);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_memDataValid = 1'b1;
            i_memData = 32'h1111_1111 * i;
            tick();
            check("c4 write", 32'(o_clutWrite), 32'h1);
            check("c4 idx", 32'(o_clutWrIdx), 32'(i));
            check("c4 data", o_wrData, 32'h1111_1111 * i);
            if (i < 7) check("c4 busy data", 32'(o_clutBusy), 32'h1);
        end
        i_memDataValid = 1'b0;
        tick();
        check("c4 done", 32'(o_clutDone), 32'h1);
        check("c4 busy after", 32'(o_clutBusy), 32'h0);
        tick();
        check("c4 done single", 32'(o_clutDone), 32'h0);

        // ---- CLUT 8bpp with a one-cycle gap after every beat ----
        i_clutLoadReq = 1'b1;
        i_clutAdr = 15'h1234;
        i_clut8bpp = 1'b1;
        tick();
        i_clutLoadReq = 1'b0;
        i_clut8bpp = 1'b0;
        tick();
        check("c8 adr", 32'(o_memAdr), 32'h091A0);
        check("c8 beats", 32'(o_memBeats), 32'h80);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int i = 0; i < 128; i++) begin
            i_memDataValid = 1'b1;
            i_memData = 32'hC000_0000 + 32'(i);
            tick();
            check("c8 write", 32'(o_clutWrite), 32'h1);
            check("c8 idx", 32'(o_clutWrIdx), 32'(i));
            check("c8 data", o_wrData, 32'hC000_0000 + 32'(i));
            i_memDataValid = 1'b0;
            tick();
            check("c8 gap no write", 32'(o_clutWrite), 32'h0);
            check("c8 done timing", 32'(o_clutDone), (i == 127) ? 32'h1 : 32'h0);
        end
        tick();
        check("c8 done single", 32'(o_clutDone), 32'h0);

        // ---- Simultaneous texture miss and CLUT pulse ----
        i_texFillReq = 1'b1;
        i_texFillAdr = 17'h1ABCD;
        i_clutLoadReq = 1'b1;
        i_clutAdr = 15'h0010;
        i_clut8bpp = 1'b0;
        tick();
        i_clutLoadReq = 1'b0;
        check("arb tex first adr", 32'(o_memAdr), 32'h3579A);
        check("arb tex first beats", 32'(o_memBeats), 32'h2);
        check("arb busy tex req", 32'(o_clutBusy), 32'h1);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_memDataValid = 1'b1;
            i_memData = 32'hD00D_0000 + 32'(i);
            tick();
            check("arb tex write", 32'(o_texWrite), 32'h1);
            check("arb tex beat", 32'(o_texWrBeat), 32'(i));
            check("arb busy tex data", 32'(o_clutBusy), 32'h1);
        end
        i_memDataValid = 1'b0;
        i_texFillReq = 1'b0;
        tick();
        check("arb tex done", 32'(o_texFillDone), 32'h1);
        check("arb busy tex done", 32'(o_clutBusy), 32'h1);
        tick();
        check("arb clut req", 32'(o_memReq), 32'h1);
        check("arb clut adr", 32'(o_memAdr), 32'h00080);
        check("arb clut beats", 32'(o_memBeats), 32'h8);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_memDataValid = 1'b1;
            i_memData = 32'hE000_0000 + 32'(i);
            tick();
            check("arb clut idx", 32'(o_clutWrIdx), 32'(i));
            check("arb clut write", 32'(o_clutWrite), 32'h1);
        end
        i_memDataValid = 1'b0;
        tick();
        check("arb clut done", 32'(o_clutDone), 32'h1);
        tick();

        // ---- Reset after the 3rd of 8 CLUT beats ----
        i_clutLoadReq = 1'b1;
        i_clutAdr = 15'h0005;
        tick();
        i_clutLoadReq = 1'b0;
        tick();
        check("rst clut adr", 32'(o_memAdr), 32'h00028);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_memDataValid = 1'b1;
            i_memData = 32'hF000_0000 + 32'(i);
            tick();
            check("rst pre write idx", 32'(o_clutWrIdx), 32'(i));
        end
        i_rst = 1'b1;
        i_memData = 32'hF000_0003;
        tick();
        i_rst = 1'b0;
        checkAllZero("mid-burst reset");
        for (int i = 4; i < 8; i++) begin
            i_memData = 32'hF000_0000 + 32'(i);
            tick();
            check("rst no write", 32'(o_clutWrite), 32'h0);
            check("rst no done", 32'(o_clutDone), 32'h0);
            check("rst no req", 32'(o_memReq), 32'h0);
        end
        i_memDataValid = 1'b0;
        tick();
        check("rst no late done", 32'(o_clutDone), 32'h0);
        check("rst busy cleared", 32'(o_clutBusy), 32'h0);

        // ---- Ack delayed 5 cycles; stray beats before ack are ignored ----
        i_texFillReq = 1'b1;
        i_texFillAdr = 17'h00ABC;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("hold req", 32'(o_memReq), 32'h1);
            check("hold adr", 32'(o_memAdr), 32'h01578);
            check("hold beats", 32'(o_memBeats), 32'h2);
            check("stray beat no write", 32'(o_texWrite), 32'h0);
            i_memDataValid = (i % 2) == 0;
            i_memData = 32'h5555_0000 + 32'(i);
            i_memAck = (i == 5);
            tick();
        end
        i_memAck = 1'b0;
        i_memDataValid = 1'b0;
        check("late ack req dropped", 32'(o_memReq), 32'h0);
        check("late ack no write", 32'(o_texWrite), 32'h0);
        for (int i = 0; i < 2; i++) begin
            i_memDataValid = 1'b1;
            i_memData = 32'h7777_0000 + 32'(i);
            tick();
            check("late ack write data", o_wrData, 32'h7777_0000 + 32'(i));
            check("late ack write line", 32'(o_texWrAdr), 32'h00ABC);
        end
        i_memDataValid = 1'b0;
        tick();
        check("late ack done", 32'(o_texFillDone), 32'h1);
        i_texFillReq = 1'b0;
        tick();
        check("late ack done single", 32'(o_texFillDone), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
